// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit RAM port between the CPU and a DMA/loader master.
// The CPU owns the port by default. A DMA request is granted after a bounded wait,
// and the CPU is stalled while the DMA owns the port. A wait counter and a burst
// counter keep either side from starving the other.
module mem_arbiter #(
  parameter int M         = 16,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpuReq,
  input  logic [M-1:0] cpuAddr,
  input  logic [M-1:0] cpuWData,
  input  logic         cpuWE,
  output logic [M-1:0] cpuRData,
  output logic         cpuStall,
  input  logic         dmaReq,
  input  logic [M-1:0] dmaAddr,
  input  logic [M-1:0] dmaWData,
  input  logic         dmaWE,
  output logic         dmaGnt,
  output logic [M-1:0] dmaRData,
  output logic         dmaValid,
  output logic [M-1:0] ramAddr,
  output logic [M-1:0] ramWData,
  output logic         ramWE,
  input  logic [M-1:0] ramRData
);

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } owner_e;

  // Both counters share one width, wide enough for the larger limit.
  localparam int CMAX = (MAX_WAIT > MAX_BURST) ? MAX_WAIT : MAX_BURST;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  owner_e         owner_q, owner_d;
  logic [CW-1:0]  waitCnt_q, waitCnt_d;
  logic [CW-1:0]  burstCnt_q, burstCnt_d;
  logic [M-1:0]   dmaRData_q, dmaRData_d;
  logic           dmaValid_q, dmaValid_d;
  logic           dmaOwns;
  logic           dmaRead;

  // While reset is low the port behaves as if the CPU owns it, so the outputs
  // are defined even before the first reset edge.
  assign dmaOwns = rst && (owner_q == DMA_OWN);
  assign dmaRead = (owner_q == DMA_OWN) && dmaReq && !dmaWE;

  // Ownership and fairness counters; counters clear on every ownership change.
  always_comb begin
    owner_d    = owner_q;
    waitCnt_d  = waitCnt_q;
    burstCnt_d = burstCnt_q;
    case (owner_q)
      CPU_OWN: begin
        if (dmaReq && (!cpuReq || (waitCnt_q == WAIT_LAST))) begin
          owner_d    = DMA_OWN;
          waitCnt_d  = '0;
          burstCnt_d = '0;
        end else if (dmaReq) begin
          waitCnt_d = waitCnt_q + 1'b1;
        end else begin
          waitCnt_d = '0;
        end
      end
      DMA_OWN: begin
        if (!dmaReq || (cpuReq && (burstCnt_q == BURST_LAST))) begin
          owner_d    = CPU_OWN;
          waitCnt_d  = '0;
          burstCnt_d = '0;
        end else if (burstCnt_q != BURST_LAST) begin
          burstCnt_d = burstCnt_q + 1'b1;
        end
      end
      default: begin
        owner_d    = CPU_OWN;
        waitCnt_d  = '0;
        burstCnt_d = '0;
      end
    endcase
  end

  // A granted DMA read is captured so the DMA sees it one cycle later.
  always_comb begin
    dmaRData_d = dmaRData_q;
    dmaValid_d = 1'b0;
    if (dmaRead) begin
      dmaRData_d = ramRData;
      dmaValid_d = 1'b1;
    end
  end

  // State registers; reset takes priority over every transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q    <= CPU_OWN;
      waitCnt_q  <= '0;
      burstCnt_q <= '0;
      dmaRData_q <= '0;
      dmaValid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      waitCnt_q  <= waitCnt_d;
      burstCnt_q <= burstCnt_d;
      dmaRData_q <= dmaRData_d;
      dmaValid_q <= dmaValid_d;
    end
  end

  // Port mux and status outputs follow the current owner.
  always_comb begin
    ramAddr  = cpuAddr;
    ramWData = cpuWData;
    ramWE    = cpuReq & cpuWE;
    if (dmaOwns) begin
      ramAddr  = dmaAddr;
      ramWData = dmaWData;
      ramWE    = dmaReq & dmaWE;
    end
  end

  assign dmaGnt   = dmaOwns;
  assign cpuStall = cpuReq & dmaOwns;
  assign cpuRData = ramRData;
  assign dmaRData = dmaRData_q;
  assign dmaValid = dmaValid_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the RCPU's single 16-bit memory port between the CPU and a DMA/loader master. It sits between `rcpu` and the RAM. The CPU normally owns the port. A DMA request is granted after a bounded wait, and the CPU is held with a stall signal while the DMA owns the port. Fairness is enforced with a wait counter and a burst counter, so neither side can starve the other.

## Interface
Parameters:
- M, 16, address/data width
- MAX_WAIT, 4, maximum cycles DMA waits while CPU holds the port (≥1)
- MAX_BURST, 2, maximum consecutive DMA-owned cycles while CPU is requesting (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 at a rising edge resets)
- cpuReq  in  1  CPU requests memory this cycle
- cpuAddr  in  M  CPU address
- cpuWData  in  M  CPU write data
- cpuWE  in  1  CPU write enable
- cpuRData  out  M  read data to CPU
- cpuStall  out  1  CPU must hold its request and state this cycle
- dmaReq  in  1  DMA requests memory this cycle
- dmaAddr  in  M  DMA address
- dmaWData  in  M  DMA write data
- dmaWE  in  1  DMA write enable
- dmaGnt  out  1  DMA owns the port this cycle
- dmaRData  out  M  registered DMA read data
- dmaValid  out  1  dmaRData holds the result of the previous cycle's DMA read
- ramAddr  out  M  RAM address
- ramWData  out  M  RAM write data
- ramWE  out  1  RAM write enable
- ramRData  in  M  RAM read data; combinational, valid in the same cycle as ramAddr

## Operation
- Two-state FSM on an owner register: CPU_OWN and DMA_OWN. Reset state is CPU_OWN.
- Counters:
  - waitCnt counts CPU_OWN cycles with dmaReq=1.
  - burstCnt counts DMA_OWN cycles.
  - Both counters clear on every state transition, and both reset to 0.
- Transitions in CPU_OWN:
  - Go to DMA_OWN when dmaReq & (!cpuReq | waitCnt==MAX_WAIT-1).
  - Otherwise stay in CPU_OWN; waitCnt increments if dmaReq=1 and clears if dmaReq=0.
- Transitions in DMA_OWN:
  - Go to CPU_OWN when !dmaReq | (cpuReq & burstCnt==MAX_BURST-1).
  - Otherwise stay; burstCnt increments and saturates at MAX_BURST-1.
- Datapath muxing is combinational on the owner register:
  - CPU_OWN: ramAddr=cpuAddr, ramWData=cpuWData, ramWE=cpuReq&cpuWE.
  - DMA_OWN: ramAddr=dmaAddr, ramWData=dmaWData, ramWE=dmaReq&dmaWE.
- Status outputs:
  - dmaGnt = (owner==DMA_OWN).
  - cpuStall = cpuReq & (owner==DMA_OWN).
- Read data:
  - cpuRData = ramRData, unregistered, in all states. The CPU ignores it while stalled.
  - DMA read: when dmaGnt & dmaReq & !dmaWE, capture dmaRData ← ramRData and set dmaValid=1 for the next cycle.
  - In all other cycles dmaValid=0 next cycle and dmaRData holds its value.
- A CPU write issued while stalled is not performed. The CPU holds it, and the write lands in the first CPU_OWN cycle.
- A cycle with dmaGnt=1 and dmaReq=0 performs no access (ramWE=0), and the FSM returns to CPU_OWN.

## Timing
- Reset values:
  - owner=CPU_OWN, waitCnt=0, burstCnt=0.
  - dmaGnt=0, cpuStall=0, dmaValid=0, dmaRData=0.
  - Combinational outputs follow CPU_OWN muxing while rst=0.
- Reset mid-burst: at the rst=0 edge, ownership returns to CPU and any pending dmaValid is dropped. This takes priority over every transition.
- Grant latency with the CPU idle: dmaReq rises in cycle t, so dmaGnt=1 in cycle t+1.
- Grant latency with cpuReq held at 1: dmaReq rises in cycle t, so dmaGnt=1 in cycle t+MAX_WAIT.
- Burst length: with cpuReq=1, the DMA holds the port for exactly MAX_BURST cycles, then the CPU gets at least MAX_WAIT cycles before the next grant.
- DMA read data: dmaValid rises 1 cycle after the granted read cycle.
- Write commit: writes commit at the rising edge that ends the cycle in which ramWE=1.
- Simultaneous events: a dmaReq fall and the burst limit in the same cycle both lead to CPU_OWN with counters cleared. When cpuReq=0 and dmaReq=1, the DMA is never pre-empted by the burst limit.

## Test plan
- Reset: hold rst=0 for 2 cycles with dmaReq=1 → dmaGnt=0, cpuStall=0, dmaValid=0, ramAddr=cpuAddr.
- CPU idle, DMA write: cpuReq=0; DMA writes 0xBEEF to 0x0040, then reads it back → dmaGnt=1 one cycle after dmaReq; RAM[0x0040]=0xBEEF; dmaRData=0xBEEF with dmaValid=1 one cycle after the read.
- Contention (MAX_WAIT=4, MAX_BURST=2): cpuReq=1 and dmaReq=1 held continuously from cycle 0 → dmaGnt high in cycles 4–5, 10–11, 16–17; cpuStall equals dmaGnt.
- Stalled CPU write: CPU holds a write of 0x1234 to 0x0010 while DMA writes 0x5678 to 0x0010 during its burst → 0x1234 lands only after the burst, so the final RAM[0x0010]=0x1234.
- dmaReq drops mid-burst: dmaReq falls in the first granted cycle → ramWE=0 in that cycle and dmaGnt=0 the next cycle.
- Reset mid-burst: assert rst=0 in the cycle a DMA read is granted → the next cycle has dmaValid=0, dmaGnt=0, and the CPU owns the port.
